// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with a memory-ready
// handshake and a wait-cycle timeout. Define MCCTRL_TRAP_EN to add the TRAP state.
module multicycle_ctrl #(
  parameter int ALUOP_W  = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               branch,
  output logic               bne,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               jal,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic [2:0]         readcontrol,
  output logic [1:0]         writecontrol,
  output logic               mem_timeout,
  output logic               illegal_op
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JAL
`ifdef MCCTRL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

`ifdef MCCTRL_TRAP_EN
  localparam state_e S_ILL = S_TRAP;
`else
  localparam state_e S_ILL = S_FETCH;
`endif

  localparam logic [CNT_W-1:0]   WMAX    = CNT_W'(WAIT_MAX);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(8);

  state_e           state_q, state_d;
  // Only the low opcode bits steer anything after DECODE.
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             mem_acc, stall, tmo;
  logic [2:0]       rd_ctl;
  logic [1:0]       wr_ctl;
  logic [ALUOP_W-1:0] i_alu;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    case (op_q[2:0])
      3'b000:  rd_ctl = 3'b000;
      3'b100:  rd_ctl = 3'b001;
      3'b001:  rd_ctl = 3'b010;
      3'b101:  rd_ctl = 3'b011;
      default: rd_ctl = 3'b100;
    endcase
    case (op_q[2:0])
      3'b000:  wr_ctl = 2'b10;
      3'b001:  wr_ctl = 2'b01;
      default: wr_ctl = 2'b00;
    endcase
    case (op_q[2:0])
      3'b010:  i_alu = ALUOP_W'(5);
      3'b011:  i_alu = ALUOP_W'(6);
      3'b100:  i_alu = ALUOP_W'(2);
      3'b101:  i_alu = ALUOP_W'(3);
      3'b110:  i_alu = ALUOP_W'(4);
      3'b111:  i_alu = ALUOP_W'(7);
      default: i_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CNT_W'(1);
    mem_req = 1'b0; iord = 1'b0; memwrite = 1'b0; irwrite = 1'b0; pcwrite = 1'b0;
    branch = 1'b0; bne = 1'b0; regwrite = 1'b0; regdst = 1'b0; memtoreg = 1'b0; jal = 1'b0;
    alusrca = 1'b0; alusrcb = 2'b00; pcsrc = 2'b00; aluop = ALU_ADD;
    readcontrol = 3'b000; writecontrol = 2'b00; mem_timeout = 1'b0; illegal_op = 1'b0;
    mem_acc = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    stall   = mem_acc && !mem_ready;
    // Fires only on the stall cycle that brings the count to WAIT_MAX; mem_ready suppresses it.
    tmo     = (WAIT_MAX != 0) && stall && (cnt_inc == WMAX);
    if (!rst) begin
      mem_timeout = tmo;
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1; alusrcb = 2'b01;
          if (mem_ready) begin
            irwrite = 1'b1; pcwrite = 1'b1; state_d = S_DECODE;
`ifdef MCCTRL_TRAP_EN
          end else if (tmo) begin
            state_d = S_TRAP;
`endif
          end
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          op_d    = op[3:0];
          casez (op)
            6'b000000: state_d = S_EXEC;
            6'b10????: state_d = S_MEMADR;
            6'b00010?: state_d = S_BRANCH;
            6'b001???: state_d = S_IEXEC;
            6'b000010: state_d = S_JUMP;
            6'b000011: state_d = S_JAL;
            default:   state_d = S_ILL;
          endcase
        end
        S_MEMADR: begin
          alusrca = 1'b1; alusrcb = 2'b10;
          state_d = op_q[3] ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_req = 1'b1; iord = 1'b1; readcontrol = rd_ctl;
          if (mem_ready) state_d = S_MEMWB;
`ifdef MCCTRL_TRAP_EN
          else if (tmo) state_d = S_TRAP;
`endif
        end
        S_MEMWB: begin
          regwrite = 1'b1; memtoreg = 1'b1; readcontrol = rd_ctl;
          state_d = S_FETCH;
        end
        S_MEMWR: begin
          mem_req = 1'b1; iord = 1'b1; memwrite = 1'b1; writecontrol = wr_ctl;
          if (mem_ready) state_d = S_FETCH;
`ifdef MCCTRL_TRAP_EN
          else if (tmo) state_d = S_TRAP;
`endif
        end
        S_EXEC:  begin alusrca = 1'b1; aluop = ALU_R; state_d = S_ALUWB; end
        S_ALUWB: begin regwrite = 1'b1; regdst = 1'b1; state_d = S_FETCH; end
        S_IEXEC: begin alusrca = 1'b1; alusrcb = 2'b10; aluop = i_alu; state_d = S_IWB; end
        S_IWB:   begin regwrite = 1'b1; state_d = S_FETCH; end
        S_BRANCH: begin
          alusrca = 1'b1; aluop = ALU_SUB; pcsrc = 2'b01; branch = 1'b1; bne = op_q[0];
          state_d = S_FETCH;
        end
        S_JUMP:  begin pcsrc = 2'b10; pcwrite = 1'b1; state_d = S_FETCH; end
        S_JAL:   begin pcsrc = 2'b10; pcwrite = 1'b1; regwrite = 1'b1; jal = 1'b1; state_d = S_FETCH; end
`ifdef MCCTRL_TRAP_EN
        S_TRAP:  illegal_op = 1'b1;
`endif
        default: state_d = S_FETCH;
      endcase
    end
    if (state_d != state_q)            cnt_d = '0;
    else if (stall && (cnt_q != WMAX)) cnt_d = cnt_inc;
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction sequences, memory stalls, timeout and reset.
module tb_multicycle_ctrl;
  typedef struct packed {
    logic [4:0] pad;
    logic mem_req, iord, memwrite, irwrite, pcwrite, branch, bne, regwrite, regdst, memtoreg, jal, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluop;
    logic [2:0] readcontrol;
    logic [1:0] writecontrol;
    logic mem_timeout, illegal_op;
  } ctl_t;

  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
  logic [5:0] op = 6'b0;
  logic mem_req, iord, memwrite, irwrite, pcwrite, branch, bne, regwrite, regdst, memtoreg, jal, alusrca;
  logic [1:0] alusrcb, pcsrc, writecontrol;
  logic [3:0] aluop;
  logic [2:0] readcontrol;
  logic mem_timeout, illegal_op;
  int n_chk = 0, n_err = 0;

  multicycle_ctrl #(.ALUOP_W(4), .WAIT_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
    .branch(branch), .bne(bne), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .jal(jal), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .readcontrol(readcontrol), .writecontrol(writecontrol), .mem_timeout(mem_timeout),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t obs();
    ctl_t o;
    o = '0;
    o.mem_req = mem_req; o.iord = iord; o.memwrite = memwrite; o.irwrite = irwrite;
    o.pcwrite = pcwrite; o.branch = branch; o.bne = bne; o.regwrite = regwrite;
    o.regdst = regdst; o.memtoreg = memtoreg; o.jal = jal; o.alusrca = alusrca;
    o.alusrcb = alusrcb; o.pcsrc = pcsrc; o.aluop = aluop; o.readcontrol = readcontrol;
    o.writecontrol = writecontrol; o.mem_timeout = mem_timeout; o.illegal_op = illegal_op;
    return o;
  endfunction

  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t e;
    e = '0; e.mem_req = 1'b1; e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy;
    return e;
  endfunction

  function automatic ctl_t e_decode();
    ctl_t e;
    e = '0; e.alusrcb = 2'b11;
    return e;
  endfunction

  function automatic ctl_t e_memadr();
    ctl_t e;
    e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic chkc(input string tag, input ctl_t exp);
    #1;
    chk(tag, obs(), exp);
  endtask

  initial begin
    ctl_t e;
    int reqs, pulses;
    rst = 1'b1; mem_ready = 1'b1; op = 6'b000000;
    cyc(); cyc();
    chkc("reset_all_zero", '0);
    rst = 1'b0;

    // add: FETCH, DECODE, EXEC, ALUWB
    chkc("add_fetch", e_fetch(1'b1));
    cyc(); chkc("add_decode", e_decode());
    cyc(); e = '0; e.alusrca = 1'b1; e.aluop = 4'd8; chkc("add_exec", e);
    cyc(); e = '0; e.regwrite = 1'b1; e.regdst = 1'b1; chkc("add_aluwb", e);
    cyc(); chkc("add_next_fetch", e_fetch(1'b1));

    // lh with three stall cycles in MEMRD
    op = 6'b100001;
    cyc(); chkc("lh_decode", e_decode());
    cyc(); chkc("lh_memadr", e_memadr());
    mem_ready = 1'b0;
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      mem_ready = (i == 3);
      #1;
      reqs += int'(mem_req);
      if (i == 0) begin
        e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.readcontrol = 3'b010;
        chk("lh_memrd_wait", obs(), e);
      end
    end
    chk("lh_memreq_cycles", reqs, 4);
    cyc(); e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1; e.readcontrol = 3'b010; chkc("lh_memwb", e);
    cyc(); chkc("lh_next_fetch", e_fetch(1'b1));

    // sb
    op = 6'b101000;
    cyc(); cyc(); chkc("sb_memadr", e_memadr());
    cyc(); e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = 1'b1; e.writecontrol = 2'b10;
    chkc("sb_memwr", e);
    cyc(); chkc("sb_next_fetch", e_fetch(1'b1));

    // bne then beq
    op = 6'b000101;
    cyc(); cyc();
    e = '0; e.alusrca = 1'b1; e.aluop = 4'd1; e.pcsrc = 2'b01; e.branch = 1'b1; e.bne = 1'b1;
    chkc("bne_branch", e);
    cyc(); chkc("bne_next_fetch", e_fetch(1'b1));
    op = 6'b000100;
    cyc(); cyc(); e.bne = 1'b0; chkc("beq_branch", e);
    cyc();

    // slti
    op = 6'b001010;
    cyc(); cyc(); e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluop = 4'd5; chkc("slti_iexec", e);
    cyc(); e = '0; e.regwrite = 1'b1; chkc("slti_iwb", e);
    cyc();

    // jal
    op = 6'b000011;
    cyc(); chkc("jal_decode", e_decode());
    cyc(); e = '0; e.pcsrc = 2'b10; e.pcwrite = 1'b1; e.regwrite = 1'b1; e.jal = 1'b1; chkc("jal_state", e);
    cyc(); chkc("jal_next_fetch", e_fetch(1'b1));

    // lw, zero wait
    op = 6'b100011;
    cyc(); cyc();
    cyc(); e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.readcontrol = 3'b100; chkc("lw_memrd", e);
    cyc(); e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1; e.readcontrol = 3'b100; chkc("lw_memwb", e);
    cyc();

    // illegal opcode
    op = 6'b111111;
    cyc(); chkc("ill_decode", e_decode());
    cyc();
`ifdef MCCTRL_TRAP_EN
    e = '0; e.illegal_op = 1'b1; chkc("ill_trap", e);
    cyc(); cyc(); chkc("ill_trap_stuck", e);
`else
    chkc("ill_nop_fetch", e_fetch(1'b1));
`endif
    rst = 1'b1; mem_ready = 1'b0; op = 6'b000000;
    chkc("ill_rst_zero", '0);
    cyc(); rst = 1'b0;

    // timeout while stalled in FETCH
    chkc("tmo_fetch_wait", e_fetch(1'b0));
    pulses = 0;
    for (int k = 1; k <= 15; k++) begin
      #1;
      if (k == 14) chk("tmo_quiet_14", mem_timeout, 1'b0);
      if (k == 15) chk("tmo_pulse_15", mem_timeout, 1'b1);
      pulses += int'(mem_timeout);
      cyc();
    end
`ifdef MCCTRL_TRAP_EN
    e = '0; e.illegal_op = 1'b1; chkc("tmo_trap", e);
`else
    for (int k = 0; k < 5; k++) begin
      #1; pulses += int'(mem_timeout);
      cyc();
    end
    chk("tmo_single_pulse", pulses, 1);
    chkc("tmo_still_waiting", e_fetch(1'b0));
`endif
    rst = 1'b1;
    chkc("tmo_rst_zero", '0);
    cyc(); rst = 1'b0;
    chkc("tmo_rst_fetch", e_fetch(1'b0));

    // mem_ready on the would-be timeout cycle suppresses the pulse
    for (int k = 1; k < 15; k++) cyc();
    mem_ready = 1'b1;
    chkc("ready_wins", e_fetch(1'b1));
    cyc(); chkc("ready_wins_decode", e_decode());

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
